// File: rtl/pmc_receiver.sv
// pmc_receiver: 32-lane serial-to-parallel receiver for the PMC return path.
// Each lane assembles a 16-bit word MSB first on pclk strobes while sh is high;
// a completed set of 32 words is published on din with a one-cycle valid pulse.
module pmc_receiver (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sh,
  input  logic             pclk,
  input  logic [31:0]      pm_dout,
  input  logic             clr,
  output logic [31:0][15:0] din,
  output logic             din_valid,
  output logic [7:0]       words_cnt,
  output logic             abort_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  bits_reg, bits_next;
  logic        shift_en;
  logic        word_done;
  logic        abort_evt;

  logic [15:0] shreg_reg [32];
  logic [15:0] din_reg   [32];
  logic        din_valid_reg;
  logic [7:0]  words_cnt_reg;
  logic        abort_err_reg;

  // State and bit-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      bits_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      bits_reg  <= bits_next;
    end
  end

  // Next-state logic; strobes are only honoured in ACTIVE with sh still high,
  // so a strobe coinciding with the sh rise or fall is dropped.
  always_comb begin
    state_next = state_reg;
    bits_next  = bits_reg;
    shift_en   = 1'b0;
    word_done  = 1'b0;
    abort_evt  = 1'b0;
    case (state_reg)
      IDLE: begin
        bits_next = 4'd0;
        if (sh) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (!sh) begin
          state_next = IDLE;
          bits_next  = 4'd0;
          abort_evt  = (bits_reg != 4'd0);
        end else if (pclk) begin
          shift_en  = 1'b1;
          word_done = (bits_reg == 4'd15);
          bits_next = bits_reg + 4'd1;  // wraps to 0 after the 16th bit
        end
      end
      default: begin
        state_next = IDLE;
        bits_next  = 4'd0;
      end
    endcase
  end

  // Per-lane shift register and output word; the output word takes the
  // incoming bit directly so it is complete on the 16th strobe itself.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_lane
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shreg_reg[gi] <= 16'd0;
          din_reg[gi]   <= 16'd0;
        end else begin
          if (shift_en)  shreg_reg[gi] <= {shreg_reg[gi][14:0], pm_dout[gi]};
          if (word_done) din_reg[gi]   <= {shreg_reg[gi][14:0], pm_dout[gi]};
        end
      end
      assign din[gi] = din_reg[gi];
    end
  endgenerate

  // Valid pulse, saturating word counter and sticky abort flag.
  // clr beats a coinciding completion; a coinciding abort beats clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_valid_reg <= 1'b0;
      words_cnt_reg <= 8'd0;
      abort_err_reg <= 1'b0;
    end else begin
      din_valid_reg <= word_done;
      if (clr)
        words_cnt_reg <= 8'd0;
      else if (word_done && words_cnt_reg != 8'hFF)
        words_cnt_reg <= words_cnt_reg + 8'd1;
      if (abort_evt)
        abort_err_reg <= 1'b1;
      else if (clr)
        abort_err_reg <= 1'b0;
    end
  end

  assign din_valid = din_valid_reg;
  assign words_cnt = words_cnt_reg;
  assign abort_err = abort_err_reg;

endmodule

// File: doc/pmc_receiver.md
# pmc_receiver

Deserializer on the return path of the pixel-matrix controller (PMC). It samples the 32-lane serial bus `pm_dout` from the pixel matrix on each `pclk` strobe while shift mode `sh` is active. It assembles one 16-bit word per lane, MSB first, and presents the 32×16 result to the PMC register file with a one-cycle valid pulse. It is the counterpart of the PMC transmitter: it uses the same `sh`/`pclk` control and the same bit ordering.

## Interface
- No parameters; lane count 32 and word width 16 are fixed.
- `clk` input 1 — system clock, all logic on rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `sh` input 1 — shift-mode enable (level), synchronous to `clk`.
- `pclk` input 1 — bit strobe, one `clk` cycle high per bit, synchronous to `clk`.
- `pm_dout` input [31:0] — serial data, one bit per lane; lane `i` feeds word `i`.
- `clr` input 1 — synchronous clear of counters and error flag.
- `din` output [31:0][15:0] — last complete received word per lane.
- `din_valid` output 1 — one-cycle pulse when `din` has just been updated.
- `words_cnt` output [7:0] — number of complete words received, saturating.
- `abort_err` output 1 — sticky flag: `sh` fell with a partial word in progress.

## Operation
- **State machine:** `IDLE`, `ACTIVE`.
- **`IDLE`:**
  - Bit counter is held at 0.
  - Moves to `ACTIVE` when `sh`=1.
  - `pclk` is ignored in `IDLE`, including a strobe in the same cycle `sh` rises.
- **`ACTIVE`:**
  - In each cycle with `pclk`=1, every lane shifts: `shreg[i] <= {shreg[i][14:0], pm_dout[i]}`, and the 4-bit `bits_counter` increments.
  - The first bit captured becomes bit 15 of the word.
- **Word complete:** on the strobe taken when `bits_counter`==15:
  - `din[i]` <= `{shreg[i][14:0], pm_dout[i]}` for all 32 lanes.
  - `bits_counter` wraps to 0.
  - `din_valid` asserts in the next cycle.
  - `words_cnt` increments; it saturates at 255.
  - The state stays `ACTIVE`, so back-to-back words need no idle gap.
- **`sh`=0 in `ACTIVE`:**
  - Return to `IDLE` and clear `bits_counter`.
  - If `bits_counter`≠0, set `abort_err` and discard the partial word; `din` keeps its previous value.
  - A `pclk` strobe in the same cycle that `sh`=0 is ignored.
- **`clr`=1:** clears `words_cnt` and `abort_err` on the next edge. It does not affect `din`, `shreg`, the state, or the counter. If `clr` and a word completion coincide, `words_cnt` becomes 0 (clear wins). If `clr` and an abort coincide, `abort_err` becomes 1 (the new event wins).
- **`din` stability:** `din` changes only on word completion and is stable between `din_valid` pulses.

## Timing
- **Reset values:** state `IDLE`, `bits_counter` 0, `shreg` all 0, `din` all 0, `din_valid` 0, `words_cnt` 0, `abort_err` 0.
- **Sampling:** `pm_dout` is sampled at the `clk` edge that ends a cycle with `sh`=1, `pclk`=1 and state `ACTIVE`. The upstream driver changes data only while `pclk`=0, so no extra synchronizer is used.
- **Latency:**
  - 16th strobe in cycle T → `din` updated at the end of T.
  - `din_valid`=1 during T+1 only.
  - `words_cnt` updated at the end of T.
- **Maximum rate:** `pclk` high in consecutive cycles is legal. This gives one bit per cycle and one word per 16 cycles.
- **`sh` rise:** `sh` rising in cycle T enables sampling from T+1.
- **Reset mid-word:** immediately returns all outputs to their reset values.

## Test plan
- **Single word:** after reset, `sh`=1, then 16 strobes with `pm_dout` lane 0 carrying 0xA5C3 MSB first and lane 31 carrying 0x8001 → `din[0]`=0xA5C3, `din[31]`=0x8001, `din_valid` is a single-cycle pulse one cycle after the 16th strobe, `words_cnt`=1.
- **Back-to-back words:** 32 consecutive-cycle strobes with `pm_dout` per lane carrying `i`, then `~i` (16-bit) → two `din_valid` pulses 16 cycles apart, final `din[i]`=~`i`, `words_cnt`=2.
- **Abort mid-word:** drop `sh` after 7 strobes → `abort_err`=1, `din` unchanged from the previous word, no `din_valid`; the next full 16-strobe word is received correctly.
- **Ignored strobes:** `pclk` strobes while `sh`=0, and a strobe in the same cycle `sh` rises → no shift, `bits_counter` 0, 16 further strobes yield the correct word.
- **Saturation and clear:** receive 260 words → `words_cnt`=255; then `clr`=1 → `words_cnt`=0, `abort_err`=0, `din` retained.
- **Async reset:** `rst_n`=0 asserted mid-word → all outputs are 0 immediately; after release, a fresh word is received correctly.
